// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: received word,
// status flags and the clear acknowledge.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_clear;
    logic                 parity_error;
    logic                 framing_error;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_error,
        output framing_error,
        output overrun,
        input  rx_clear
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_error,
        input  framing_error,
        input  overrun,
        output rx_clear
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, qualifies the start bit, samples
// mid-bit and holds the word plus status until the consumer clears.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     rx,
    output logic     busy,
    uart_rx_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST    = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_tick;
    logic                 w_commit;
    logic                 w_rx_s;
    logic                 w_par_calc;
    logic [1:0]           r_sync;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_ovr;

    assign w_rx_s     = r_sync[1];
    assign w_commit   = (r_state == S_STOP) && w_tick;
    assign w_par_calc = (^r_shift) ^ (PARITY_ODD != 0);
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_tick = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rx_s) w_next = S_START;
            end
            S_START: begin
                w_tick = (r_cnt == HALF_M1);
                if (w_tick) w_next = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                w_tick = (r_cnt == FULL_M1);
                if (w_tick && r_idx == LAST)
                    w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                w_tick = (r_cnt == FULL_M1);
                if (w_tick) w_next = S_STOP;
            end
            S_STOP: begin
                w_tick = (r_cnt == FULL_M1);
                if (w_tick) w_next = w_rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (w_rx_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync    <= 2'b11;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx};
            // Counter restarts on every state entry and every bit sample
            if (r_state != w_next || w_tick || r_state == S_IDLE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_IDLE && w_next == S_START) begin
                r_idx     <= '0;
                r_par_err <= 1'b0;
            end
            if (r_state == S_DATA && w_tick) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                r_idx   <= r_idx + 1'b1;
            end
            if (r_state == S_PARITY && w_tick)
                r_par_err <= (w_par_calc != w_rx_s);
            if (w_commit) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_perr  <= r_par_err;
                r_ferr  <= ~w_rx_s;
                r_ovr   <= r_valid & ~bus.rx_clear;
            end else if (bus.rx_clear) begin
                r_valid <= 1'b0;
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign bus.rx_data       = r_data;
    assign bus.rx_valid      = r_valid;
    assign bus.parity_error  = r_perr;
    assign bus.framing_error = r_ferr;
    assign bus.overrun       = r_ovr;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: 16 clocks/bit, 8E1 frames, expected words
// queued as frames are driven and compared after each frame.
module tb_uart_rx;
    localparam int C  = 16;
    localparam int DB = 8;
    localparam int PE = 1;
    localparam int PO = 0;
    localparam int NB = 1 + DB + PE + 1;
    localparam int STOP_EDGE = 3 + C / 2 + (DB + PE + 1) * C;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rx    = 1'b1;
    logic busy;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (DB),
        .PARITY_EN   (PE),
        .PARITY_ODD  (PO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .busy (busy),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
        logic          ovr;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    exp_t exp_v;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Drives one frame; rx_clear is pulsed in cycle clr_at (-1: never)
    task automatic send_frame(input logic [DB-1:0] d, input logic par_ok,
                              input logic stop, input int clr_at);
        logic [NB-1:0] bits;
        logic          p;
        p = (^d) ^ (PO != 0);
        if (!par_ok) p = ~p;
        bits = {stop, p, d, 1'b0};
        for (int c = 0; c < NB * C; c++) begin
            rx           = bits[c / C];
            bus.rx_clear = (c == clr_at);
            @(posedge clk);
            #1;
        end
        bus.rx_clear = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.rx_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_clear = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if ({bus.rx_data, bus.rx_valid, bus.parity_error,
             bus.framing_error, bus.overrun, busy} !== '0)
            $display("FAIL reset_state got=%h exp=0",
                     {bus.rx_data, bus.rx_valid, bus.parity_error,
                      bus.framing_error, bus.overrun, busy});
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int n;
        n = 0;
        sb.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
        fork
            send_frame(8'hA5, 1'b1, 1'b1, -1);
            begin
                while (!bus.rx_valid && n < 400) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        n_chk++;
        if (n !== STOP_EDGE)
            $display("FAIL valid_latency got=%0d exp=%0d", n, STOP_EDGE);
        else n_pass++;
        got   = {bus.rx_data, bus.parity_error,
                 bus.framing_error, bus.overrun};
        exp_v = sb.pop_front();
        n_chk++;
        if (got !== exp_v)
            $display("FAIL basic_word got=%h exp=%h", got, exp_v);
        else n_pass++;
        n_chk++;
        if (bus.rx_valid !== 1'b1)
            $display("FAIL basic_valid got=%b exp=1", bus.rx_valid);
        else n_pass++;
        pulse_clear();
        n_chk++;
        if (bus.rx_valid !== 1'b0)
            $display("FAIL clear_valid got=%b exp=0", bus.rx_valid);
        else n_pass++;
        n_chk++;
        if (bus.rx_data !== 8'hA5)
            $display("FAIL clear_keeps_data got=%h exp=a5", bus.rx_data);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int   first;
        logic at11;
        first = 0;
        at11  = 1'b1;
        rx    = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) rx = 1'b1;
            if (busy && first == 0) first = i;
            if (i == 11) at11 = busy;
        end
        n_chk++;
        if (first !== 3)
            $display("FAIL glitch_busy_rise got=%0d exp=3", first);
        else n_pass++;
        n_chk++;
        if (at11 !== 1'b0)
            $display("FAIL glitch_idle got=%b exp=0", at11);
        else n_pass++;
        n_chk++;
        if ({bus.rx_valid, busy} !== 2'b00)
            $display("FAIL glitch_no_output got=%b exp=00",
                     {bus.rx_valid, busy});
        else n_pass++;
    endtask

    task automatic test_parity();
        sb.push_back('{8'h01, 1'b1, 1'b0, 1'b0});
        send_frame(8'h01, 1'b0, 1'b1, -1);
        got   = {bus.rx_data, bus.parity_error,
                 bus.framing_error, bus.overrun};
        exp_v = sb.pop_front();
        n_chk++;
        if (got !== exp_v)
            $display("FAIL parity_word got=%h exp=%h", got, exp_v);
        else n_pass++;
        n_chk++;
        if (bus.rx_valid !== 1'b1)
            $display("FAIL parity_valid got=%b exp=1", bus.rx_valid);
        else n_pass++;
        pulse_clear();
    endtask

    task automatic test_break();
        int bad;
        int n;
        bad = 0;
        n   = 0;
        sb.push_back('{8'h3C, 1'b0, 1'b1, 1'b0});
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        got   = {bus.rx_data, bus.parity_error,
                 bus.framing_error, bus.overrun};
        exp_v = sb.pop_front();
        n_chk++;
        if (got !== exp_v)
            $display("FAIL framing_word got=%h exp=%h", got, exp_v);
        else n_pass++;
        n_chk++;
        if ({bus.rx_valid, busy} !== 2'b11)
            $display("FAIL framing_valid_busy got=%b exp=11",
                     {bus.rx_valid, busy});
        else n_pass++;
        pulse_clear();
        for (int i = 0; i < 40 * C; i++) begin
            @(posedge clk);
            #1;
            if (bus.rx_valid || !busy) bad++;
        end
        n_chk++;
        if (bad !== 0)
            $display("FAIL break_hold got=%0d exp=0", bad);
        else n_pass++;
        rx = 1'b1;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_chk++;
        if (n !== 3)
            $display("FAIL break_exit got=%0d exp=3", n);
        else n_pass++;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_overrun();
        sb.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
        send_frame(8'h11, 1'b1, 1'b1, -1);
        got   = {bus.rx_data, bus.parity_error,
                 bus.framing_error, bus.overrun};
        exp_v = sb.pop_front();
        n_chk++;
        if (got !== exp_v)
            $display("FAIL ovr_first got=%h exp=%h", got, exp_v);
        else n_pass++;
        sb.push_back('{8'h22, 1'b0, 1'b0, 1'b1});
        send_frame(8'h22, 1'b1, 1'b1, -1);
        got   = {bus.rx_data, bus.parity_error,
                 bus.framing_error, bus.overrun};
        exp_v = sb.pop_front();
        n_chk++;
        if (got !== exp_v)
            $display("FAIL ovr_second got=%h exp=%h", got, exp_v);
        else n_pass++;
        pulse_clear();
        sb.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
        send_frame(8'h11, 1'b1, 1'b1, -1);
        got   = {bus.rx_data, bus.parity_error,
                 bus.framing_error, bus.overrun};
        exp_v = sb.pop_front();
        n_chk++;
        if (got !== exp_v)
            $display("FAIL clrsim_first got=%h exp=%h", got, exp_v);
        else n_pass++;
        sb.push_back('{8'h22, 1'b0, 1'b0, 1'b0});
        send_frame(8'h22, 1'b1, 1'b1, STOP_EDGE - 1);
        got   = {bus.rx_data, bus.parity_error,
                 bus.framing_error, bus.overrun};
        exp_v = sb.pop_front();
        n_chk++;
        if (got !== exp_v)
            $display("FAIL clrsim_second got=%h exp=%h", got, exp_v);
        else n_pass++;
        n_chk++;
        if (bus.rx_valid !== 1'b1)
            $display("FAIL clrsim_valid got=%b exp=1", bus.rx_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [NB-1:0] bits;
        bits = {1'b1, 1'b0, 8'h5A, 1'b0};
        for (int c = 0; c < 70; c++) begin
            rx = bits[c / C];
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        n_chk++;
        if ({bus.rx_data, bus.rx_valid, bus.parity_error,
             bus.framing_error, bus.overrun, busy} !== '0)
            $display("FAIL reset_mid got=%h exp=0",
                     {bus.rx_data, bus.rx_valid, bus.parity_error,
                      bus.framing_error, bus.overrun, busy});
        else n_pass++;
        rx = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        got   = {bus.rx_data, bus.parity_error,
                 bus.framing_error, bus.overrun};
        exp_v = sb.pop_front();
        n_chk++;
        if (got !== exp_v)
            $display("FAIL after_reset_word got=%h exp=%h", got, exp_v);
        else n_pass++;
        n_chk++;
        if (bus.rx_valid !== 1'b1)
            $display("FAIL after_reset_valid got=%b exp=1", bus.rx_valid);
        else n_pass++;
    endtask

    initial begin
        bus.rx_clear = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_break();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
